ptp_tsq_regs: RTL and testbench
===============================

PTP_TSQ_REGS -- requirements
Module: ptp_tsq_regs

Interface
REQ-001 SHALL have parameter N_CH, default 2, giving the number of timestamp-queue channels (1..4).
REQ-002 SHALL have parameter Q_DW, default 128, giving the queue entry width; legal values are 32, 64, 96 and 128.
REQ-003 SHALL have parameter RD_LAT, default 1, giving the queue read-data latency in cycles after rd_en (1..4).
REQ-004 SHALL have parameter ADDR_W, default 8, giving the byte-address width.
REQ-005 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic runs on it.
- rst_n  in  1  reset, asynchronous assert, active-low.
- wr_in  in  1  bus write strobe.
- rd_in  in  1  bus read strobe.
- addr_in  in  ADDR_W  byte address; bits [1:0] ignored.
- data_in  in  32  write data.
- data_out  out  32  registered read data.
- q_rst_out  out  N_CH  per-channel queue reset, 1-cycle pulse.
- q_rd_en_out  out  N_CH  per-channel queue pop, 1-cycle pulse.
- q_msgid_mask_out  out  8*N_CH  per-channel PTP messageId mask.
- q_empty_in  in  N_CH  per-channel queue empty flag.
- q_stat_in  in  8*N_CH  per-channel queue status/level.
- q_data_in  in  Q_DW*N_CH  per-channel queue head data.
- irq_out  out  1  OR of all enabled pending interrupts.

Function
REQ-006 SHALL decode channel c at byte base c*0x20 with eight words: +00 CTRL, +04 STAT, +08 IRQ, +0C IRQ_EN, +10..+1C DATA0..DATA3 (DATA0 = MS word).
REQ-007 CTRL writes SHALL act as strobes: bit0 = read request, bit1 = queue reset; CTRL SHALL read back as {30'd0, busy, ok}.
REQ-008 STAT SHALL read as {mask[7:0], 15'd0, empty, q_stat[7:0]}; only bits [31:24] are writable, and they drive q_msgid_mask_out.
REQ-009 IRQ bits SHALL be: bit0 = read-done, bit1 = empty-error, bit2 = overrun; all are sticky and write-1-to-clear.
REQ-010 IRQ_EN [2:0] SHALL be read/write.
REQ-011 irq_out SHALL equal the OR over all channels of (IRQ & IRQ_EN), registered.
REQ-012 Each channel SHALL run an FSM with states IDLE, POP, WAIT, CAPT.
REQ-013 In IDLE, a read request with empty=0 SHALL go to POP, clear ok and set busy.
REQ-014 In IDLE, a read request with empty=1 SHALL stay in IDLE and set IRQ bit1; ok is unchanged.
REQ-015 POP SHALL assert q_rd_en_out for exactly 1 cycle, then go to WAIT.
REQ-016 WAIT SHALL count RD_LAT-1 cycles, then go to CAPT; when RD_LAT=1, WAIT lasts zero cycles.
REQ-017 CAPT SHALL latch q_data_in into DATA0..DATA3, set ok, clear busy, set IRQ bit0 and return to IDLE.
REQ-018 Latency SHALL be: request write at cycle T -> q_rd_en at T+1 -> ok visible at T+2+RD_LAT.
REQ-019 A read request while busy SHALL be ignored and SHALL set IRQ bit2.
REQ-020 A queue-reset strobe SHALL pulse q_rst_out on the next cycle, abort the FSM to IDLE, and clear ok and busy; when both bits are written together, reset wins.
REQ-021 DATA words beyond Q_DW/32 SHALL read 0.
REQ-022 Reserved offsets and channels >= N_CH SHALL read 0 and ignore writes.
REQ-023 data_out SHALL update in the cycle after rd_in and hold its value otherwise.
REQ-024 A W1C write coincident with a set event on the same bit SHALL leave the bit set.
REQ-025 Simultaneous wr_in and rd_in to the same address SHALL return the pre-write value.

Reset
REQ-026 rst_n low SHALL asynchronously set all outputs, masks, IRQ, IRQ_EN, DATA, ok, busy and data_out to 0, and put every FSM in IDLE.
REQ-027 Reset deassertion SHALL take effect on the next clk edge; no pulses are generated during or at release.

Structure
REQ-028 Package ptp_regs_pkg SHALL hold the word-offset constants, IRQ bit indices and the FSM state type.
REQ-029 Per-channel logic (FSM, ok/busy, IRQ, mask, data latch) SHALL be sub-module ptp_tsq_chan, instantiated N_CH times by generate.
REQ-030 The top level SHALL hold only address decode, the read mux, data_out and the irq_out OR.

Verification
REQ-031 N_CH=2, Q_DW=128, RD_LAT=2: ch1 empty=0, q_data=0x0123..CDEF; write 0x20<=1 -> exactly one q_rd_en_out[1] pulse; after 4 cycles CTRL reads 0x1; reads of 0x30..0x3C return the four data words MS-first.
REQ-032 Empty error: ch0 empty=1, write 0x00<=1 -> no q_rd_en_out pulse; IRQ@0x08 reads 0x2; write 0x08<=0x2 -> reads 0x0.
REQ-033 Overrun: write 0x00<=1 twice back-to-back -> one q_rd_en_out pulse; IRQ reads 0x5 after completion.
REQ-034 Abort: write 0x00<=1, then 0x00<=2 during WAIT -> one q_rst_out[0] pulse; CTRL reads 0x0; no read-done bit.
REQ-035 IRQ: IRQ_EN@0x0C<=1 and a completed read -> irq_out=1; W1C 0x08<=1 -> irq_out=0 the cycle after.
REQ-036 Q_DW=64: DATA2/DATA3 read 0; unmapped 0x60 reads 0; rst_n low mid-WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/ptp_regs_pkg.sv
// Shared constants and types for the PTP timestamp-queue register block.
// Word offsets within a channel window, IRQ bit indices, channel FSM state.
package ptp_regs_pkg;

  localparam logic [2:0] OFF_CTRL  = 3'd0;
  localparam logic [2:0] OFF_STAT  = 3'd1;
  localparam logic [2:0] OFF_IRQ   = 3'd2;
  localparam logic [2:0] OFF_IRQEN = 3'd3;
  localparam logic [2:0] OFF_DATA0 = 3'd4;

  localparam int CTRL_RD  = 0;
  localparam int CTRL_RST = 1;

  localparam int IRQ_DONE  = 0;
  localparam int IRQ_EMPTY = 1;
  localparam int IRQ_OVR   = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_WAIT,
    S_CAPT
  } chan_state_e;

endpackage

// File: rtl/ptp_tsq_regs_if.sv
// Simple register bus: write/read strobes, word address, data both ways.
// Read data is combinational from the slave; the master registers it.
interface ptp_tsq_regs_if #(
  parameter int AW = 8
) ();

  logic          wr;
  logic          rd;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;

  modport master (
    output wr, rd, addr, wdata,
    input  rdata
  );

  modport slave (
    input  wr, rd, addr, wdata,
    output rdata
  );

endinterface

// File: rtl/ptp_tsq_chan.sv
// One timestamp-queue channel: pop FSM, ok/busy, IRQ, mask and data latch.
// Register window is 8 words, addressed by a 3-bit word offset.
module ptp_tsq_chan
  import ptp_regs_pkg::*;
#(
  parameter int Q_DW   = 128,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  ptp_tsq_regs_if.slave   bus,
  input  logic            i_empty,
  input  logic [7:0]      i_stat,
  input  logic [Q_DW-1:0] i_qdata,
  output logic            o_qrst,
  output logic            o_rd_en,
  output logic [7:0]      o_mask,
  output logic            o_irq
);

  localparam int NW = Q_DW / 32;
  localparam logic [1:0] LAT_END = 2'(RD_LAT > 1 ? RD_LAT - 2 : 0);

  chan_state_e     r_state, w_nxt;
  logic [1:0]      r_cnt, w_cnt_nxt;
  logic            r_ok, r_busy, r_qrst;
  logic [2:0]      r_irq, r_irq_en;
  logic [7:0]      r_mask;
  logic [Q_DW-1:0] r_data;

  logic w_wr_ctrl, w_wr_stat, w_wr_irq, w_wr_en;
  logic w_req, w_abort;
  logic w_start, w_capt, w_ovr, w_eerr;
  logic [2:0]  w_irq_set, w_irq_clr;
  logic [31:0] w_dw [4];
  logic        w_unused;

  assign w_wr_ctrl = bus.wr && (bus.addr == OFF_CTRL);
  assign w_wr_stat = bus.wr && (bus.addr == OFF_STAT);
  assign w_wr_irq  = bus.wr && (bus.addr == OFF_IRQ);
  assign w_wr_en   = bus.wr && (bus.addr == OFF_IRQEN);
  assign w_abort   = w_wr_ctrl && bus.wdata[CTRL_RST];
  assign w_req     = w_wr_ctrl && bus.wdata[CTRL_RD];
  assign w_unused  = ^bus.wdata[23:3];

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_start   = 1'b0;
    w_capt    = 1'b0;
    w_ovr     = 1'b0;
    w_eerr    = 1'b0;
    if (w_abort) begin
      w_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req && i_empty) begin
            w_eerr = 1'b1;
          end else if (w_req) begin
            w_nxt   = S_POP;
            w_start = 1'b1;
          end
        end
        S_POP: begin
          w_ovr     = w_req;
          w_cnt_nxt = '0;
          w_nxt     = (RD_LAT == 1) ? S_CAPT : S_WAIT;
        end
        S_WAIT: begin
          w_ovr = w_req;
          if (r_cnt == LAT_END) w_nxt = S_CAPT;
          else w_cnt_nxt = r_cnt + 2'd1;
        end
        S_CAPT: begin
          w_ovr  = w_req;
          w_capt = 1'b1;
          w_nxt  = S_IDLE;
        end
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_irq_set            = '0;
    w_irq_set[IRQ_DONE]  = w_capt;
    w_irq_set[IRQ_EMPTY] = w_eerr;
    w_irq_set[IRQ_OVR]   = w_ovr;
    w_irq_clr            = w_wr_irq ? bus.wdata[2:0] : 3'b0;
  end

  // A set event in the same cycle as its W1C keeps the bit set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ok     <= 1'b0;
      r_busy   <= 1'b0;
      r_qrst   <= 1'b0;
      r_irq    <= '0;
      r_irq_en <= '0;
      r_mask   <= '0;
      r_data   <= '0;
    end else begin
      r_qrst <= w_abort;
      r_irq  <= (r_irq & ~w_irq_clr) | w_irq_set;
      if (w_wr_en)   r_irq_en <= bus.wdata[2:0];
      if (w_wr_stat) r_mask   <= bus.wdata[31:24];
      if (w_abort) begin
        r_ok   <= 1'b0;
        r_busy <= 1'b0;
      end else if (w_start) begin
        r_ok   <= 1'b0;
        r_busy <= 1'b1;
      end else if (w_capt) begin
        r_ok   <= 1'b1;
        r_busy <= 1'b0;
        r_data <= i_qdata;
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_dw
    if (k < NW) begin : g_on
      assign w_dw[k] = r_data[Q_DW-1-32*k -: 32];
    end else begin : g_off
      assign w_dw[k] = '0;
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.rd) begin
      unique case (bus.addr)
        OFF_CTRL:  bus.rdata = {30'd0, r_busy, r_ok};
        OFF_STAT:  bus.rdata = {r_mask, 15'd0, i_empty, i_stat};
        OFF_IRQ:   bus.rdata = {29'd0, r_irq};
        OFF_IRQEN: bus.rdata = {29'd0, r_irq_en};
        default:   bus.rdata = w_dw[bus.addr[1:0]];
      endcase
    end
  end

  assign o_qrst  = r_qrst;
  assign o_rd_en = (r_state == S_POP);
  assign o_mask  = r_mask;
  assign o_irq   = |(r_irq & r_irq_en);

endmodule

// File: rtl/ptp_tsq_regs.sv
// PTP timestamp-queue register block: channel decode, read mux, IRQ OR.
// Each channel occupies a 0x20-byte window; unmapped channels read 0.
module ptp_tsq_regs
  import ptp_regs_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int Q_DW   = 128,
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_in,
  input  logic                 rd_in,
  input  logic [ADDR_W-1:0]    addr_in,
  input  logic [31:0]          data_in,
  output logic [31:0]          data_out,
  output logic [N_CH-1:0]      q_rst_out,
  output logic [N_CH-1:0]      q_rd_en_out,
  output logic [8*N_CH-1:0]    q_msgid_mask_out,
  input  logic [N_CH-1:0]      q_empty_in,
  input  logic [8*N_CH-1:0]    q_stat_in,
  input  logic [Q_DW*N_CH-1:0] q_data_in,
  output logic                 irq_out
);

  localparam int CW = ADDR_W - 5;

  logic [CW-1:0]   w_ch;
  logic [31:0]     w_rdata [N_CH];
  logic [31:0]     w_rd_mux;
  logic [N_CH-1:0] w_irq;
  logic [31:0]     r_data_out;
  logic            r_irq;
  logic            w_unused;

  assign w_ch     = addr_in[ADDR_W-1:5];
  assign w_unused = ^addr_in[1:0];

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    ptp_tsq_regs_if #(.AW(3)) u_bus ();

    assign u_bus.wr    = wr_in && (w_ch == CW'(c));
    assign u_bus.rd    = rd_in && (w_ch == CW'(c));
    assign u_bus.addr  = addr_in[4:2];
    assign u_bus.wdata = data_in;
    assign w_rdata[c]  = u_bus.rdata;

    ptp_tsq_chan #(
      .Q_DW   (Q_DW),
      .RD_LAT (RD_LAT)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (u_bus),
      .i_empty (q_empty_in[c]),
      .i_stat  (q_stat_in[8*c +: 8]),
      .i_qdata (q_data_in[Q_DW*c +: Q_DW]),
      .o_qrst  (q_rst_out[c]),
      .o_rd_en (q_rd_en_out[c]),
      .o_mask  (q_msgid_mask_out[8*c +: 8]),
      .o_irq   (w_irq[c])
    );
  end

  always_comb begin
    w_rd_mux = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (w_ch == CW'(c)) w_rd_mux = w_rdata[c];
    end
  end

  // Read data samples pre-write state, so a same-cycle write is not seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (rd_in) r_data_out <= w_rd_mux;
      r_irq <= |w_irq;
    end
  end

  assign data_out = r_data_out;
  assign irq_out  = r_irq;

endmodule

// File: tb/tb_ptp_tsq_regs.sv
// Directed bench for ptp_tsq_regs: register table plus FSM sequences.
// dut1: N_CH=2 Q_DW=128 RD_LAT=2; dut2: N_CH=2 Q_DW=64 RD_LAT=1.
module tb_ptp_tsq_regs;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ptp_tsq_regs_if #(.AW(8)) b1 ();
  ptp_tsq_regs_if #(.AW(8)) b2 ();

  logic [1:0]   e1, e2;
  logic [15:0]  st1, st2;
  logic [255:0] qd1;
  logic [127:0] qd2;
  logic [1:0]   qrst1, rden1, qrst2, rden2;
  logic [15:0]  msk1, msk2;
  logic         irq1, irq2;

  ptp_tsq_regs #(
    .N_CH(2), .Q_DW(128), .RD_LAT(2), .ADDR_W(8)
  ) u_dut1 (
    .clk              (clk),
    .rst_n            (rst_n),
    .wr_in            (b1.wr),
    .rd_in            (b1.rd),
    .addr_in          (b1.addr),
    .data_in          (b1.wdata),
    .data_out         (b1.rdata),
    .q_rst_out        (qrst1),
    .q_rd_en_out      (rden1),
    .q_msgid_mask_out (msk1),
    .q_empty_in       (e1),
    .q_stat_in        (st1),
    .q_data_in        (qd1),
    .irq_out          (irq1)
  );

  ptp_tsq_regs #(
    .N_CH(2), .Q_DW(64), .RD_LAT(1), .ADDR_W(8)
  ) u_dut2 (
    .clk              (clk),
    .rst_n            (rst_n),
    .wr_in            (b2.wr),
    .rd_in            (b2.rd),
    .addr_in          (b2.addr),
    .data_in          (b2.wdata),
    .data_out         (b2.rdata),
    .q_rst_out        (qrst2),
    .q_rd_en_out      (rden2),
    .q_msgid_mask_out (msk2),
    .q_empty_in       (e2),
    .q_stat_in        (st2),
    .q_data_in        (qd2),
    .irq_out          (irq2)
  );

  int errs = 0;
  int checks = 0;
  int n_rd0 = 0;
  int n_rd1 = 0;
  int n_rst0 = 0;

  always @(posedge clk) begin
    if (rden1[0]) n_rd0++;
    if (rden1[1]) n_rd1++;
    if (qrst1[0]) n_rst0++;
  end

  typedef struct {
    bit          w;
    bit          r;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;

  vec_t tv [16];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic bus(int d, bit w, bit r, logic [7:0] a, logic [31:0] v);
    if (d == 0) begin
      b1.wr = w; b1.rd = r; b1.addr = a; b1.wdata = v;
    end else begin
      b2.wr = w; b2.rd = r; b2.addr = a; b2.wdata = v;
    end
    @(negedge clk);
    b1.wr = 1'b0; b1.rd = 1'b0;
    b2.wr = 1'b0; b2.rd = 1'b0;
  endtask

  task automatic wr(int d, logic [7:0] a, logic [31:0] v);
    bus(d, 1'b1, 1'b0, a, v);
  endtask

  task automatic rd(int d, logic [7:0] a, logic [31:0] exp, string nm);
    bus(d, 1'b0, 1'b1, a, 32'h0);
    chk(nm, (d == 0) ? b1.rdata : b2.rdata, exp);
  endtask

  int s0, s1, sr;

  initial begin
    b1.wr = 0; b1.rd = 0; b1.addr = 0; b1.wdata = 0;
    b2.wr = 0; b2.rd = 0; b2.addr = 0; b2.wdata = 0;
    e1 = 2'b01;
    e2 = 2'b00;
    st1 = {8'hC3, 8'h5A};
    st2 = 16'h0;
    qd1 = {32'h01234567, 32'h89ABCDEF, 32'h13579BDF, 32'h2468ACE0, 128'h0};
    qd2 = {64'h0, 64'hDEADBEEF_CAFEF00D};

    tv = '{
      '{0, 1, 8'h00, 32'h0,        32'h0},
      '{0, 1, 8'h04, 32'h0,        32'h0000015A},
      '{0, 1, 8'h24, 32'h0,        32'h000000C3},
      '{0, 1, 8'h08, 32'h0,        32'h0},
      '{1, 0, 8'h04, 32'hFFFFFFFF, 32'h0},
      '{0, 1, 8'h04, 32'h0,        32'hFF00015A},
      '{1, 0, 8'h0C, 32'hFFFFFFFF, 32'h0},
      '{0, 1, 8'h0C, 32'h0,        32'h7},
      '{1, 1, 8'h0C, 32'h4,        32'h7},
      '{0, 1, 8'h0C, 32'h0,        32'h4},
      '{1, 0, 8'h0C, 32'h0,        32'h0},
      '{0, 1, 8'h40, 32'h0,        32'h0},
      '{1, 0, 8'h44, 32'hFFFFFFFF, 32'h0},
      '{0, 1, 8'h44, 32'h0,        32'h0},
      '{1, 0, 8'h10, 32'hFFFFFFFF, 32'h0},
      '{0, 1, 8'h10, 32'h0,        32'h0}
    };

    #12;
    chk("rst data_out", b1.rdata, 32'h0);
    chk("rst rd_en", {30'd0, rden1}, 32'h0);
    chk("rst q_rst", {30'd0, qrst1}, 32'h0);
    chk("rst mask", {16'd0, msk1}, 32'h0);
    chk("rst irq", {31'd0, irq1}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      bus(0, tv[i].w, tv[i].r, tv[i].a, tv[i].d);
      if (tv[i].r) chk($sformatf("vec%0d", i), b1.rdata, tv[i].e);
    end
    chk("mask out", {16'd0, msk1}, 32'h000000FF);

    // empty error
    s0 = n_rd0;
    wr(0, 8'h00, 32'h1);
    repeat (4) @(negedge clk);
    chk("empty no pop", n_rd0 - s0, 0);
    rd(0, 8'h08, 32'h2, "empty irq");
    rd(0, 8'h00, 32'h0, "empty ctrl");
    wr(0, 8'h08, 32'h2);
    rd(0, 8'h08, 32'h0, "empty w1c");

    // full pop on ch1, RD_LAT=2
    s1 = n_rd1;
    wr(0, 8'h20, 32'h1);
    chk("pop T+1", {31'd0, rden1[1]}, 32'h1);
    rd(0, 8'h20, 32'h2, "ctrl T+1");
    rd(0, 8'h20, 32'h2, "ctrl T+2");
    rd(0, 8'h20, 32'h2, "ctrl T+3");
    rd(0, 8'h20, 32'h1, "ctrl T+4");
    chk("ch1 one pop", n_rd1 - s1, 1);
    rd(0, 8'h28, 32'h1, "ch1 done irq");
    rd(0, 8'h30, 32'h01234567, "data0");
    rd(0, 8'h34, 32'h89ABCDEF, "data1");
    rd(0, 8'h38, 32'h13579BDF, "data2");
    rd(0, 8'h3C, 32'h2468ACE0, "data3");
    @(negedge clk);
    chk("data_out hold", b1.rdata, 32'h2468ACE0);

    // overrun
    e1 = 2'b00;
    s0 = n_rd0;
    wr(0, 8'h00, 32'h1);
    wr(0, 8'h00, 32'h1);
    repeat (6) @(negedge clk);
    rd(0, 8'h08, 32'h5, "ovr irq");
    rd(0, 8'h00, 32'h1, "ovr ctrl");
    chk("ovr one pop", n_rd0 - s0, 1);

    // irq_out
    wr(0, 8'h08, 32'h7);
    wr(0, 8'h0C, 32'h1);
    chk("irq idle", {31'd0, irq1}, 32'h0);
    wr(0, 8'h00, 32'h1);
    repeat (5) @(negedge clk);
    chk("irq set", {31'd0, irq1}, 32'h1);
    wr(0, 8'h08, 32'h1);
    chk("irq lag", {31'd0, irq1}, 32'h1);
    @(negedge clk);
    chk("irq clr", {31'd0, irq1}, 32'h0);

    // W1C in the same cycle as read-done
    wr(0, 8'h00, 32'h1);
    repeat (2) @(negedge clk);
    wr(0, 8'h08, 32'h1);
    repeat (2) @(negedge clk);
    rd(0, 8'h08, 32'h1, "w1c vs set");
    wr(0, 8'h08, 32'h7);

    // abort during WAIT
    s0 = n_rd0;
    sr = n_rst0;
    wr(0, 8'h00, 32'h1);
    @(negedge clk);
    wr(0, 8'h00, 32'h2);
    chk("qrst pulse", {31'd0, qrst1[0]}, 32'h1);
    @(negedge clk);
    chk("qrst end", {31'd0, qrst1[0]}, 32'h0);
    rd(0, 8'h00, 32'h0, "abort ctrl");
    repeat (4) @(negedge clk);
    rd(0, 8'h08, 32'h0, "abort irq");
    chk("abort one pop", n_rd0 - s0, 1);
    chk("abort one rst", n_rst0 - sr, 1);

    // dut2: Q_DW=64, RD_LAT=1
    wr(1, 8'h00, 32'h1);
    rd(1, 8'h00, 32'h2, "d2 ctrl T+1");
    rd(1, 8'h00, 32'h2, "d2 ctrl T+2");
    rd(1, 8'h00, 32'h1, "d2 ctrl T+3");
    rd(1, 8'h10, 32'hDEADBEEF, "d2 data0");
    rd(1, 8'h14, 32'hCAFEF00D, "d2 data1");
    rd(1, 8'h18, 32'h0, "d2 data2");
    rd(1, 8'h1C, 32'h0, "d2 data3");
    rd(1, 8'h60, 32'h0, "d2 unmapped");

    // async reset in the middle of WAIT
    rd(0, 8'h30, 32'h01234567, "pre-rst data");
    wr(0, 8'h20, 32'h1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst data_out", b1.rdata, 32'h0);
    chk("arst mask", {16'd0, msk1}, 32'h0);
    chk("arst rd_en", {30'd0, rden1}, 32'h0);
    chk("arst q_rst", {30'd0, qrst1}, 32'h0);
    chk("arst irq", {31'd0, irq1}, 32'h0);
    s1 = n_rd1;
    sr = n_rst0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post-rst no pop", n_rd1 - s1, 0);
    chk("post-rst no qrst", n_rst0 - sr, 0);
    rd(0, 8'h20, 32'h0, "post-rst ctrl");
    rd(0, 8'h30, 32'h0, "post-rst data");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
